// File: rtl/regfile_wb_arbiter.sv
// Purpose: round-robin write-back arbiter (ALU vs load path) for the single register file write port, plus per-register busy scoreboard.
// Latency: handshake in cycle N drives rf_reg_write/rf_rd/rf_data and clears busy in cycle N+1; ready is same-cycle combinational.
// Backpressure: exactly one requester is accepted per cycle; the loser sees ready=0 and must hold valid/rd/data until accepted.
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   alu_valid/alu_rd/alu_data/alu_ready   ALU write-back request channel
//   mem_valid/mem_rd/mem_data/mem_ready   load write-back request channel
//   rf_reg_write/rf_rd/rf_data        registered register file write port
//   rsv_valid/rsv_rd                  issue-stage destination reservation
//   rs1_sel/rs2_sel, rs1_busy/rs2_busy  issue-stage pending-write lookup
//   flush                             synchronous clear of every busy bit

module regfile_wb_arbiter #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_REGS = 16
) (
    input  logic              clk,
    input  logic              rst_n,

    // ALU write-back request
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,

    // Memory / load write-back request
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,

    // Register file write port
    output logic              rf_reg_write,
    output logic [ADDR_W-1:0] rf_rd,
    output logic [DATA_W-1:0] rf_data,

    // Scoreboard interface to the issue stage
    input  logic              rsv_valid,
    input  logic [ADDR_W-1:0] rsv_rd,
    input  logic [ADDR_W-1:0] rs1_sel,
    input  logic [ADDR_W-1:0] rs2_sel,
    output logic              rs1_busy,
    output logic              rs2_busy,
    input  logic              flush
);

    // Which requester won most recently; the other one wins the next conflict.
    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_MEM = 1'b1
    } grant_e;

    // Register 0 is hard-wired and indices beyond NUM_REGS have no storage,
    // so neither is ever written nor tracked as busy.
    function automatic logic in_range(input logic [ADDR_W-1:0] r);
        return (r != '0) && (32'(r) < NUM_REGS);
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    grant_e                last_grant_q, last_grant_d;
    logic                  rf_reg_write_q, rf_reg_write_d;
    logic [ADDR_W-1:0]     rf_rd_q, rf_rd_d;
    logic [DATA_W-1:0]     rf_data_q, rf_data_d;
    logic [NUM_REGS-1:0]   busy_q, busy_d;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic              grant_alu;
    logic              grant_mem;
    logic              wb_fire;
    logic [ADDR_W-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              wb_commit;

    always_comb begin
        // ALU wins when alone, or on a conflict when MEM won last time.
        grant_alu = alu_valid && (!mem_valid || (last_grant_q == GRANT_MEM));
        grant_mem = mem_valid && !grant_alu;
    end

    assign alu_ready = grant_alu;
    assign mem_ready = grant_mem;

    always_comb begin
        wb_fire   = grant_alu || grant_mem;
        wb_rd     = grant_alu ? alu_rd   : mem_rd;
        wb_data   = grant_alu ? alu_data : mem_data;
        // Out-of-range or r0 writes still handshake and still count for
        // round-robin; only the register file enable is suppressed.
        wb_commit = wb_fire && in_range(wb_rd);
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (grant_alu) begin
            last_grant_d = GRANT_ALU;
        end else if (grant_mem) begin
            last_grant_d = GRANT_MEM;
        end
    end

    // ------------------------------------------------------------------
    // Write port: select/data hold their last value when idle.
    // ------------------------------------------------------------------
    always_comb begin
        rf_reg_write_d = wb_commit;
        rf_rd_d        = rf_rd_q;
        rf_data_d      = rf_data_q;
        if (wb_fire) begin
            rf_rd_d   = wb_rd;
            rf_data_d = wb_data;
        end
    end

    assign rf_reg_write = rf_reg_write_q;
    assign rf_rd        = rf_rd_q;
    assign rf_data      = rf_data_q;

    // ------------------------------------------------------------------
    // Scoreboard
    // Order of precedence, lowest first: clear by write-back, set by
    // reservation (a newer producer now owns the register), flush.
    // ------------------------------------------------------------------
    logic rsv_set;

    assign rsv_set = rsv_valid && in_range(rsv_rd);

    always_comb begin
        busy_d = busy_q;
        for (int i = 1; i < int'(NUM_REGS); i++) begin
            if (wb_commit && (wb_rd == ADDR_W'(i))) begin
                busy_d[i] = 1'b0;
            end
            if (rsv_set && (rsv_rd == ADDR_W'(i))) begin
                busy_d[i] = 1'b1;
            end
        end
        if (flush) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    // Lookups read registered state only; a write-back clearing the same
    // register this cycle is not forwarded.
    always_comb begin
        rs1_busy = 1'b0;
        rs2_busy = 1'b0;
        for (int i = 1; i < int'(NUM_REGS); i++) begin
            if (rs1_sel == ADDR_W'(i)) begin
                rs1_busy = busy_q[i];
            end
            if (rs2_sel == ADDR_W'(i)) begin
                rs2_busy = busy_q[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Flops
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // Start as if MEM won last, so the first conflict goes to ALU.
            last_grant_q   <= GRANT_MEM;
            rf_reg_write_q <= 1'b0;
            rf_rd_q        <= '0;
            rf_data_q      <= '0;
            busy_q         <= '0;
        end else begin
            last_grant_q   <= last_grant_d;
            rf_reg_write_q <= rf_reg_write_d;
            rf_rd_q        <= rf_rd_d;
            rf_data_q      <= rf_data_d;
            busy_q         <= busy_d;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Purpose: directed self-checking bench for regfile_wb_arbiter.
// Latency: checks registered outputs 1 time unit after the rising edge.
// Backpressure: requesters hold valid/rd/data until their ready is seen.

module tb_regfile_wb_arbiter;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 16;

    logic              clk;
    logic              rst_n;
    logic              alu_valid;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;
    logic              mem_valid;
    logic [ADDR_W-1:0] mem_rd;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;
    logic              rf_reg_write;
    logic [ADDR_W-1:0] rf_rd;
    logic [DATA_W-1:0] rf_data;
    logic              rsv_valid;
    logic [ADDR_W-1:0] rsv_rd;
    logic [ADDR_W-1:0] rs1_sel;
    logic [ADDR_W-1:0] rs2_sel;
    logic              rs1_busy;
    logic              rs2_busy;
    logic              flush;

    int n_checks = 0;
    int n_errors = 0;

    regfile_wb_arbiter #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .NUM_REGS(NUM_REGS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .alu_ready   (alu_ready),
        .mem_valid   (mem_valid),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .mem_ready   (mem_ready),
        .rf_reg_write(rf_reg_write),
        .rf_rd       (rf_rd),
        .rf_data     (rf_data),
        .rsv_valid   (rsv_valid),
        .rsv_rd      (rsv_rd),
        .rs1_sel     (rs1_sel),
        .rs2_sel     (rs2_sel),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .flush       (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit past the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
        rsv_valid = 1'b0; rsv_rd = '0;
        flush     = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        idle_inputs();
        #1;
        chk("rst_we",   32'(rf_reg_write), 32'd0);
        chk("rst_rd",   32'(rf_rd),        32'd0);
        chk("rst_data", rf_data,           32'd0);
        cyc();
        #2;
        rst_n = 1'b1;
        cyc();
    endtask

    initial begin
        rst_n   = 1'b1;
        rs1_sel = '0;
        rs2_sel = '0;
        idle_inputs();

        // ---------------- reset + single ALU write ----------------
        do_reset();
        chk("rst_rs1_busy", 32'(rs1_busy), 32'd0);
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hDEADBEEF;
        #1;
        chk("t1_alu_ready", 32'(alu_ready), 32'd1);
        chk("t1_mem_ready", 32'(mem_ready), 32'd0);
        cyc();
        alu_valid = 1'b0;
        chk("t1_we",   32'(rf_reg_write), 32'd1);
        chk("t1_rd",   32'(rf_rd),        32'd3);
        chk("t1_data", rf_data,           32'hDEADBEEF);
        cyc();
        chk("t1_we_off",   32'(rf_reg_write), 32'd0);
        chk("t1_rd_hold",  32'(rf_rd),        32'd3);
        chk("t1_data_hold", rf_data,          32'hDEADBEEF);

        // ---------------- contention alternates ----------------
        do_reset();
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h0000_0011;
        mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 32'h0000_0022;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("t2_alu_ready%0d", i), 32'(alu_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("t2_mem_ready%0d", i), 32'(mem_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
            cyc();
            chk($sformatf("t2_we%0d", i),   32'(rf_reg_write), 32'd1);
            chk($sformatf("t2_rd%0d", i),   32'(rf_rd),   (i % 2 == 0) ? 32'd1 : 32'd2);
            chk($sformatf("t2_data%0d", i), rf_data,      (i % 2 == 0) ? 32'h11 : 32'h22);
        end
        idle_inputs();
        cyc();

        // ---------------- discarded writes still count ----------------
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h0000_0099;
        cyc();
        alu_valid = 1'b0;
        chk("t3_alu9_we", 32'(rf_reg_write), 32'd1);
        mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h0000_0A0A;
        #1;
        chk("t3_r0_ready", 32'(mem_ready), 32'd1);
        cyc();
        chk("t3_r0_we", 32'(rf_reg_write), 32'd0);
        chk("t3_r0_rd", 32'(rf_rd),        32'd0);
        mem_rd = 5'd20; mem_data = 32'h0000_1414;
        #1;
        chk("t3_r20_ready", 32'(mem_ready), 32'd1);
        cyc();
        chk("t3_r20_we", 32'(rf_reg_write), 32'd0);
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h0000_0101;
        #1;
        chk("t3_conf_alu", 32'(alu_ready), 32'd1);
        chk("t3_conf_mem", 32'(mem_ready), 32'd0);
        cyc();
        idle_inputs();
        chk("t3_conf_rd", 32'(rf_rd), 32'd1);
        cyc();

        // ---------------- reserve / clear ----------------
        rs1_sel = 5'd5; rs2_sel = 5'd0;
        rsv_valid = 1'b1; rsv_rd = 5'd5;
        #1;
        chk("t4_no_bypass_set", 32'(rs1_busy), 32'd0);
        cyc();
        rsv_valid = 1'b0;
        chk("t4_busy5", 32'(rs1_busy), 32'd1);
        chk("t4_r0",    32'(rs2_busy), 32'd0);
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h0000_0555;
        #1;
        chk("t4_no_bypass_clr", 32'(rs1_busy), 32'd1);
        cyc();
        alu_valid = 1'b0;
        chk("t4_clr5", 32'(rs1_busy), 32'd0);
        // Out-of-range reservation has no effect.
        rsv_valid = 1'b1; rsv_rd = 5'd20; rs2_sel = 5'd20;
        cyc();
        rsv_valid = 1'b0;
        chk("t4_oor_busy", 32'(rs2_busy), 32'd0);

        // ---------------- set wins over clear, then flush ----------------
        rs1_sel = 5'd7;
        rsv_valid = 1'b1; rsv_rd = 5'd7;
        cyc();
        chk("t5_busy7", 32'(rs1_busy), 32'd1);
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h0000_0777;
        cyc();
        idle_inputs();
        chk("t5_set_wins", 32'(rs1_busy), 32'd1);
        chk("t5_we7",      32'(rf_reg_write), 32'd1);
        rs2_sel = 5'd3;
        flush = 1'b1; rsv_valid = 1'b1; rsv_rd = 5'd3;
        mem_valid = 1'b1; mem_rd = 5'd6; mem_data = 32'h0000_0666;
        #1;
        chk("t5_flush_ready", 32'(mem_ready), 32'd1);
        cyc();
        idle_inputs();
        chk("t5_flush7", 32'(rs1_busy), 32'd0);
        chk("t5_flush3", 32'(rs2_busy), 32'd0);
        chk("t5_flush_we", 32'(rf_reg_write), 32'd1);
        chk("t5_flush_rd", 32'(rf_rd), 32'd6);
        cyc();

        // ---------------- async reset mid-operation ----------------
        rs1_sel = 5'd4;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h0000_CAFE;
        rsv_valid = 1'b1; rsv_rd = 5'd4;
        cyc();
        idle_inputs();
        chk("t6_we",    32'(rf_reg_write), 32'd1);
        chk("t6_busy4", 32'(rs1_busy),     32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_arst_we",   32'(rf_reg_write), 32'd0);
        chk("t6_arst_rd",   32'(rf_rd),        32'd0);
        chk("t6_arst_data", rf_data,           32'd0);
        chk("t6_arst_busy", 32'(rs1_busy),     32'd0);
        // Requests during reset are not accepted into state.
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h0000_BEEF;
        cyc();
        chk("t6_hold_we", 32'(rf_reg_write), 32'd0);
        idle_inputs();
        #2;
        rst_n = 1'b1;
        cyc();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
